// File: rtl/ps2_key_decoder_pkg.sv
// ps2_key_decoder_pkg: prefix/modifier codes, rx state encoding, decoder state and set-2 to ASCII map
package ps2_key_decoder_pkg;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS = 8'h58;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef struct packed {
    logic       ext, brk, lsh, rsh, caps;
    logic [7:0] held, ascii, scan;
    logic       sv, kb, ek, perr;
  } dec_t;
  function automatic logic [7:0] ascii_map(input logic [7:0] code, input logic shift, input logic caps);
    logic [7:0] let_c;
    logic [15:0] sym;
    let_c = 8'h00;
    sym = 16'h0000;
    case (code)
      8'h1C: let_c = "a";  8'h32: let_c = "b";  8'h21: let_c = "c";  8'h23: let_c = "d";
      8'h24: let_c = "e";  8'h2B: let_c = "f";  8'h34: let_c = "g";  8'h33: let_c = "h";
      8'h43: let_c = "i";  8'h3B: let_c = "j";  8'h42: let_c = "k";  8'h4B: let_c = "l";
      8'h3A: let_c = "m";  8'h31: let_c = "n";  8'h44: let_c = "o";  8'h4D: let_c = "p";
      8'h15: let_c = "q";  8'h2D: let_c = "r";  8'h1B: let_c = "s";  8'h2C: let_c = "t";
      8'h3C: let_c = "u";  8'h2A: let_c = "v";  8'h1D: let_c = "w";  8'h22: let_c = "x";
      8'h35: let_c = "y";  8'h1A: let_c = "z";
      default: ;
    endcase
    // sym packs {shifted, unshifted}
    case (code)
      8'h45: sym = {")", "0"};  8'h16: sym = {"!", "1"};  8'h1E: sym = {"@", "2"};
      8'h26: sym = {"#", "3"};  8'h25: sym = {"$", "4"};  8'h2E: sym = {"%", "5"};
      8'h36: sym = {"^", "6"};  8'h3D: sym = {"&", "7"};  8'h3E: sym = {"*", "8"};
      8'h46: sym = {"(", "9"};  8'h0E: sym = {"~", 8'h60}; 8'h4E: sym = {"_", "-"};
      8'h55: sym = {"+", "="};  8'h54: sym = {"{", "["};  8'h5B: sym = {"}", "]"};
      8'h5D: sym = {"|", 8'h5C}; 8'h4C: sym = {":", ";"};  8'h52: sym = {8'h22, 8'h27};
      8'h41: sym = {"<", ","};  8'h49: sym = {">", "."};  8'h4A: sym = {"?", "/"};
      8'h5A: sym = {8'h0D, 8'h0D}; 8'h66: sym = {8'h08, 8'h08}; 8'h29: sym = {8'h20, 8'h20};
      8'h0D: sym = {8'h09, 8'h09}; 8'h76: sym = {8'h1B, 8'h1B};
      default: ;
    endcase
    return (let_c != 8'h00) ? ((shift ^ caps) ? let_c - 8'h20 : let_c) : (shift ? sym[15:8] : sym[7:0]);
  endfunction
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: decoded key event bus from the decoder (master) to the keystroke FIFO (slave)
interface ps2_key_decoder_if;
  logic [7:0] ascii_key, scan_code;
  logic       scan_valid, key_break, ext_key, shift_on, caps_on, parity_err;
  modport master(output ascii_key, scan_code, scan_valid, key_break, ext_key, shift_on, caps_on, parity_err);
  modport slave(input ascii_key, scan_code, scan_valid, key_break, ext_key, shift_on, caps_on, parity_err);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// ps2_key_decoder_rx: pad synchronisers, ps2_clk glitch filter and 11-bit frame receiver.
// PS2_TIMEOUT_EN adds a mid-frame idle timeout that aborts the frame.
module ps2_key_decoder_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_sync_q, dat_sync_q;
  logic [FW-1:0] flt_cnt_q;
  logic filt_q, flt_edge, fall, dat, timeout;
  rx_state_t state_q, state_d;
  logic [2:0] bits_q, bits_d;
  logic [7:0] sr_q, sr_d;
  logic par_q, par_d;
  assign flt_edge = (clk_sync_q[1] != filt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
  assign fall = flt_edge & filt_q;
  assign dat = dat_sync_q[1];
  assign byte_o = sr_q;
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  assign timeout = (state_q != RX_IDLE) && !flt_edge && (to_q == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else to_q <= (flt_edge || state_q == RX_IDLE) ? '0 : to_q + 1'b1;
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_comb begin
    state_d = state_q;
    bits_d = bits_q;
    sr_d = sr_q;
    par_d = par_q;
    byte_valid_o = 1'b0;
    frame_err_o = 1'b0;
    if (fall)
      case (state_q)
        RX_IDLE: if (!dat) begin
          state_d = RX_DATA;
          bits_d = 3'd0;
          par_d = 1'b0;
        end
        RX_DATA: begin
          sr_d = {dat, sr_q[7:1]};
          par_d = par_q ^ dat;
          bits_d = bits_q + 3'd1;
          state_d = (bits_q == 3'd7) ? RX_PARITY : RX_DATA;
        end
        RX_PARITY: begin
          par_d = par_q ^ dat;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          byte_valid_o = dat & par_q;
          frame_err_o = ~(dat & par_q);
        end
      endcase
    if (timeout) begin
      state_d = RX_IDLE;
      frame_err_o = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q <= 1'b1;
      flt_cnt_q <= '0;
      state_q <= RX_IDLE;
      bits_q <= '0;
      sr_q <= '0;
      par_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      flt_cnt_q <= (flt_edge || clk_sync_q[1] == filt_q) ? '0 : flt_cnt_q + 1'b1;
      if (flt_edge) filt_q <= clk_sync_q[1];
      state_q <= state_d;
      bits_q <= bits_d;
      sr_q <= sr_d;
      par_q <= par_d;
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard front end; E0/F0 prefix and modifier tracking, set-2 to ASCII.
// PS2_TIMEOUT_EN enables the receiver's mid-frame timeout.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_key_decoder_if.master key
);
  logic [7:0] rx_byte, mapped;
  logic rx_valid, rx_err;
  dec_t st_q, st_d;
  ps2_key_decoder_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .byte_o(rx_byte), .byte_valid_o(rx_valid), .frame_err_o(rx_err)
  );
  always_comb begin
    mapped = ascii_map(rx_byte, st_q.lsh | st_q.rsh, st_q.caps);
    st_d = st_q;
    st_d.sv = 1'b0;
    st_d.perr = 1'b0;
    if (rx_err) begin
      st_d.perr = 1'b1;
      st_d.ext = 1'b0;
      st_d.brk = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PFX_EXT) st_d.ext = 1'b1;
      else if (rx_byte == PFX_BRK) st_d.brk = 1'b1;
      else begin
        st_d.sv = 1'b1;
        st_d.scan = rx_byte;
        st_d.kb = st_q.brk;
        st_d.ek = st_q.ext;
        st_d.ext = 1'b0;
        st_d.brk = 1'b0;
        // extended codes never map and never touch modifiers or the held key
        if (!st_q.ext) begin
          if (rx_byte == KEY_LSHIFT) st_d.lsh = !st_q.brk;
          if (rx_byte == KEY_RSHIFT) st_d.rsh = !st_q.brk;
          if (rx_byte == KEY_CAPS && !st_q.brk) st_d.caps = !st_q.caps;
          if (!st_q.brk && mapped != 8'h00) begin
            st_d.ascii = mapped;
            st_d.held = rx_byte;
          end
          if (st_q.brk && rx_byte == st_q.held) st_d.ascii = 8'h00;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= '0;
    else st_q <= st_d;
  assign key.ascii_key = st_q.ascii;
  assign key.scan_code = st_q.scan;
  assign key.scan_valid = st_q.sv;
  assign key.key_break = st_q.kb;
  assign key.ext_key = st_q.ek;
  assign key.shift_on = st_q.lsh | st_q.rsh;
  assign key.caps_on = st_q.caps;
  assign key.parity_err = st_q.perr;
endmodule
